pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Reset sequencer immediately downstream of the Cyclone V PLL wrapper.
- Consumes the PLL `locked` flag and drives the PLL `rst` input; issues staged, glitch-free reset releases to the memory controller and then the CPU/system.
- Runs on the free-running 50 MHz board clock, the same net as the PLL refclk, so it keeps working while the PLL is unlocked.
- Watchdogs PLL lock and re-pulses the PLL reset if lock never arrives.

## Interface
Parameters:
- LOCK_STABLE, 1024: cycles the synchronised lock must stay high before memory reset release.
- STAGE_DELAY, 256: cycles between memory reset release and system reset release.
- LOCK_TIMEOUT, 5000000: cycles in WAITLOCK before the PLL reset is re-pulsed (100 ms at 50 MHz).
- PLL_RST_CYCLES, 16: width of the `pll_rst` pulse.

Ports:
- clk  in  1  board clock, same net as PLL refclk.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL locked flag; asynchronous to clk.
- ext_reset_n  in  1  user reset button, active-low, asynchronous.
- pll_rst  out  1  active-high reset to the PLL `rst` input.
- mem_reset_n  out  1  active-low reset for the SDRAM/memory domain.
- sys_reset_n  out  1  active-low reset for the CPU/system domain.
- ready  out  1  high only in RUN.
- relock_count  out  8  count of lock losses, saturating at 255.

## Operation
- `pll_locked` and `ext_reset_n` each pass through a 2-flop synchroniser, giving `locked_s` and `ext_s`. The flops reset to 0.
- One shared cycle counter `cnt` has width $clog2 of the largest parameter. It clears on every state change.
- State machine states: PLLRST, WAITLOCK, STABLE, MEMREL, RUN.
- PLLRST: stay for PLL_RST_CYCLES cycles, then go to WAITLOCK.
- WAITLOCK:
  - `locked_s`=1: go to STABLE.
  - Otherwise increment `cnt`. When `cnt` reaches LOCK_TIMEOUT-1, go to PLLRST.
- STABLE:
  - `locked_s`=0: go to WAITLOCK.
  - `ext_s`=0: hold `cnt` at 0.
  - After LOCK_STABLE cycles: go to MEMREL.
- MEMREL: after STAGE_DELAY cycles, go to RUN.
- Lock loss: `locked_s`=0 in STABLE, MEMREL or RUN goes to WAITLOCK and increments `relock_count`, saturating at 255.
- External reset: `ext_s`=0 in MEMREL or RUN goes to STABLE with `cnt`=0. `relock_count` is unchanged.
- Priority: lock loss wins over `ext_s`, which wins over counter expiry.
- Outputs are registered and updated on the same edge as the state register; each equals the decode of the new state:
  - `pll_rst`=1 only in PLLRST.
  - `mem_reset_n`=1 in MEMREL and RUN.
  - `sys_reset_n`=1 and `ready`=1 only in RUN.
- Reset values (`reset_n` low, applied asynchronously at any time, including mid-RUN):
  - state = PLLRST, `cnt`=0, `relock_count`=0.
  - `pll_rst`=1, `mem_reset_n`=0, `sys_reset_n`=0, `ready`=0.

## Timing
- `pll_rst` is high for exactly PLL_RST_CYCLES cycles after `reset_n` deasserts, and for exactly PLL_RST_CYCLES cycles on each watchdog re-pulse.
- Watchdog: `pll_rst` rises LOCK_TIMEOUT cycles after entering WAITLOCK if `locked_s` stays 0.
- Lock rise, with `pll_locked` high before edge k:
  - `locked_s`=1 after edge k+1.
  - STABLE after edge k+2.
  - `mem_reset_n` rises after edge k+2+LOCK_STABLE.
  - `sys_reset_n` and `ready` rise after edge k+2+LOCK_STABLE+STAGE_DELAY.
- Lock loss, with `pll_locked` low before edge j: all resets assert and `ready` falls after edge j+2. `relock_count` updates on the same edge.
- `ext_reset_n` takes the same 2-cycle path. Release timing counts from the edge on which `ext_s` returns to 1.
- A single-cycle `locked_s` drop in STABLE restarts the full LOCK_STABLE count. Outputs never glitch because they are all registered.
- `ext_reset_n` has no effect in PLLRST or WAITLOCK.

## Test plan
Parameters for all scenarios: LOCK_STABLE=8, STAGE_DELAY=4, LOCK_TIMEOUT=32, PLL_RST_CYCLES=3.
1. Release `reset_n`, hold `pll_locked`=0 -> `pll_rst` high for 3 cycles, low for 32, high for 3 again. All other outputs stay at reset values.
2. Raise `pll_locked` before edge k while in WAITLOCK -> `mem_reset_n`=1 after edge k+10; `sys_reset_n`=1 and `ready`=1 after edge k+14; `relock_count`=0.
3. In RUN, drop `pll_locked` before edge j -> all resets low and `ready`=0 after edge j+2, `relock_count`=1. Restoring lock repeats the 8/4-cycle release sequence.
4. In RUN, hold `ext_reset_n`=0 for 5 cycles -> `mem_reset_n`/`sys_reset_n` low 2 cycles later, `pll_rst` stays 0, `relock_count` unchanged. `mem_reset_n` rises 8 cycles after `ext_s` returns to 1 and `sys_reset_n` 4 cycles after that.
5. Toggle lock 260 times -> `relock_count` saturates at 255. Simultaneous lock loss and `ext_reset_n`=0 increments the count and enters WAITLOCK.
6. Assert `reset_n` mid-RUN, asynchronously -> outputs return immediately to reset values (`pll_rst`=1, `relock_count`=0) without waiting for a clk edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the board PLL: pulses the PLL reset, watchdogs lock, and
// releases the memory and system resets in stages once lock has been stable.
module pll_reset_sequencer #(
   parameter int unsigned LOCK_STABLE    = 1024,
   parameter int unsigned STAGE_DELAY    = 256,
   parameter int unsigned LOCK_TIMEOUT   = 5000000,
   parameter int unsigned PLL_RST_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       ext_reset_n,
   output logic       pll_rst,
   output logic       mem_reset_n,
   output logic       sys_reset_n,
   output logic       ready,
   output logic [7:0] relock_count
);

   localparam int unsigned MAX_AB  = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
   localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);

   typedef enum logic [2:0] {
      PLLRST,
      WAITLOCK,
      STABLE,
      MEMREL,
      RUN
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             lock_lost;

   logic lock_meta;
   logic locked_s;
   logic ext_meta;
   logic ext_s;

   // Both asynchronous inputs cross into clk through two flops each.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         locked_s  <= 1'b0;
         ext_meta  <= 1'b0;
         ext_s     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge
         // value, so the two synchroniser stages really are two cycles apart.
         lock_meta <= pll_locked;
         locked_s  <= lock_meta;
         ext_meta  <= ext_reset_n;
         ext_s     <= ext_meta;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_next = state;
      cnt_next   = cnt + 1'b1;
      lock_lost  = 1'b0;

      case (state)
         PLLRST: begin
            if (cnt == RST_LAST) state_next = WAITLOCK;
         end
         WAITLOCK: begin
            if (locked_s)                state_next = STABLE;
            else if (cnt == TIMEOUT_LAST) state_next = PLLRST;
         end
         STABLE: begin
            if (!locked_s) begin
               state_next = WAITLOCK;
               lock_lost  = 1'b1;
            end else if (!ext_s) begin
               cnt_next = '0;
            end else if (cnt == STABLE_LAST) begin
               state_next = MEMREL;
            end
         end
         MEMREL: begin
            if (!locked_s) begin
               state_next = WAITLOCK;
               lock_lost  = 1'b1;
            end else if (!ext_s) begin
               state_next = STABLE;
            end else if (cnt == STAGE_LAST) begin
               state_next = RUN;
            end
         end
         RUN: begin
            cnt_next = '0;
            if (!locked_s) begin
               state_next = WAITLOCK;
               lock_lost  = 1'b1;
            end else if (!ext_s) begin
               state_next = STABLE;
            end
         end
         default: state_next = PLLRST;
      endcase

      if (state_next != state) cnt_next = '0;
   end

   // Outputs decode the next state so they change on the same edge as state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= PLLRST;
         cnt          <= '0;
         relock_count <= 8'd0;
         pll_rst      <= 1'b1;
         mem_reset_n  <= 1'b0;
         sys_reset_n  <= 1'b0;
         ready        <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         pll_rst     <= (state_next == PLLRST);
         mem_reset_n <= (state_next == MEMREL) || (state_next == RUN);
         sys_reset_n <= (state_next == RUN);
         ready       <= (state_next == RUN);
         if (lock_lost && (relock_count != 8'hFF)) relock_count <= relock_count + 8'd1;
      end
   end

endmodule
